axi_mem_arbiter: RTL
====================

Name: axi_mem_arbiter

Overview:
- Shares the core's single AXI master port among three requesters: instruction cache (I, read-only bursts), data cache (D, read/write bursts) and the uncached data path (U, single-beat read/write).
- Read and write channels are arbitrated independently. Each channel carries one transaction at a time, with fixed priority U > D > I.
- Sits between the cache/uncached controllers and the core's top-level AXI interface.

Parameters:
- ID_I, 4'd0, ARID driven for I transactions
- ID_D, 4'd1, ARID/AWID driven for D transactions
- ID_U, 4'd2, ARID/AWID driven for U transactions

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- {i,d,u}_araddr  in  32  read address per requester
- {i,d,u}_arlen  in  8  burst length-1
- {i,d,u}_arsize  in  3  beat size
- {i,d,u}_arvalid  in  1  read request
- {i,d,u}_arready  out  1  read address accepted
- {i,d,u}_rdata  out  32  read data (m_rdata fanned out)
- {i,d,u}_rlast  out  1  last beat (m_rlast fanned out)
- {i,d,u}_rvalid  out  1  beat valid for this requester
- {i,d,u}_rready  in  1  requester accepts beat
- {d,u}_awaddr  in  32  write address
- {d,u}_awlen  in  8  write burst length-1
- {d,u}_awsize  in  3  write beat size
- {d,u}_awvalid  in  1  write address request
- {d,u}_awready  out  1  write address accepted
- {d,u}_wdata  in  32  write data
- {d,u}_wstrb  in  4  byte strobes
- {d,u}_wlast  in  1  last write beat
- {d,u}_wvalid  in  1  write beat valid
- {d,u}_wready  out  1  write beat accepted
- {d,u}_bvalid  out  1  write response
- {d,u}_bready  in  1  requester accepts response
- u_wbusy  out  1  U write outstanding (AW accepted, B not yet returned)
- m_ar{id[4],addr[32],len[8],size[3],valid}  out  master read address
- m_arready  in  1
- m_r{data[32],last,valid}  in
- m_rready  out  1
- m_aw{id[4],addr[32],len[8],size[3],valid}  out  master write address
- m_awready  in  1
- m_w{data[32],strb[4],last,valid}  out
- m_wready  in  1
- m_bvalid  in  1
- m_bready  out  1

Behaviour:
- Reset (rst=0, async): both FSMs go to IDLE and the grant registers clear.
  - All valid/ready outputs are 0 immediately, including mid-burst; the in-flight transaction is abandoned.
  - m_arburst/awburst are not ports; INCR is implied at top level.
- Read FSM states: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: if any eligible arvalid, latch rgnt = highest priority (U>D>I) and go to R_ADDR.
  - U is ineligible while u_wbusy=1 or a U write is in W_ADDR. This preserves MMIO write-then-read order.
  - R_ADDR: m_ar* are muxed from rgnt and m_arvalid = granted arvalid. X_arready = m_arready for the granted requester only. On handshake, go to R_DATA.
  - R_DATA: X_rvalid = m_rvalid for the granted requester only, and m_rready = granted rready.
  - On m_rvalid & m_rready & m_rlast, return to R_IDLE. The earliest next AR is 2 cycles later: a 1-cycle bubble in R_IDLE.
  - m_rvalid in R_IDLE/R_ADDR is ignored and m_rready=0.
- Write FSM states: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: latch wgnt, priority U > D.
  - W_ADDR: m_aw* muxed from wgnt. Exit on AW handshake.
  - W_DATA: m_w* muxed from wgnt. Exit on W handshake with m_wlast=1.
  - W_RESP: m_bready = granted bready, X_bvalid = m_bvalid. Exit on B handshake.
  - W is never issued before AW. Non-granted {aw,w}ready and bvalid stay 0.
- u_wbusy: registered.
  - Set on the cycle after a U AW handshake.
  - Cleared on the cycle after the U B handshake.
- Channel independence: read and write FSMs advance concurrently. The only coupling is the U read hold-off above.
- Grants are held for the whole transaction. A requester dropping valid after grant is a protocol violation and is not checked.
- Fixed priority: I can starve under continuous D/U traffic. This is acceptable by design.

Test Plan:
- I reads araddr=0xBFC00000, arlen=7, m_arready=1 → m_arvalid in cycle 2 with m_arid=0; 8 beats reach i_rvalid only; i_rlast on beat 8; R_IDLE the cycle after.
- I, D and U arvalid raised together → U granted first (m_arid=2), then D, then I, each separated by a 1-cycle bubble; non-granted arready stay 0.
- U write 0x1FAF0000 data 0x12345678 strb 4'hF, with a U read of the same address one cycle later → m_arvalid stays 0 until the B handshake; u_wbusy goes 1→0; the read then issues.
- D 4-beat write concurrent with an I 8-beat read, m_bvalid delayed 5 cycles → both complete; data, strobes and order are unaltered; d_bvalid pulses once.
- rst driven low mid-burst in R_DATA and W_DATA → all m_*valid/m_*ready go 0 asynchronously; after release, a new I read is granted normally.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI master port between I-cache, D-cache and uncached requesters.
// Read and write channels each carry one transaction at a time, fixed priority U > D > I.
module axi_mem_arbiter #(
  parameter logic [3:0] ID_I = 4'd0,
  parameter logic [3:0] ID_D = 4'd1,
  parameter logic [3:0] ID_U = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,  d_araddr,  u_araddr,
  input  logic [7:0]  i_arlen,   d_arlen,   u_arlen,
  input  logic [2:0]  i_arsize,  d_arsize,  u_arsize,
  input  logic        i_arvalid, d_arvalid, u_arvalid,
  output logic        i_arready, d_arready, u_arready,
  output logic [31:0] i_rdata,   d_rdata,   u_rdata,
  output logic        i_rlast,   d_rlast,   u_rlast,
  output logic        i_rvalid,  d_rvalid,  u_rvalid,
  input  logic        i_rready,  d_rready,  u_rready,
  input  logic [31:0] d_awaddr,  u_awaddr,
  input  logic [7:0]  d_awlen,   u_awlen,
  input  logic [2:0]  d_awsize,  u_awsize,
  input  logic        d_awvalid, u_awvalid,
  output logic        d_awready, u_awready,
  input  logic [31:0] d_wdata,   u_wdata,
  input  logic [3:0]  d_wstrb,   u_wstrb,
  input  logic        d_wlast,   u_wlast,
  input  logic        d_wvalid,  u_wvalid,
  output logic        d_wready,  u_wready,
  output logic        d_bvalid,  u_bvalid,
  input  logic        d_bready,  u_bready,
  output logic        u_wbusy,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  output logic        m_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {GNT_I, GNT_D, GNT_U} gnt_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  gnt_t     rgnt, rgnt_next, wgnt, wgnt_next;
  logic     sel_arvalid, sel_rready, sel_wvalid, sel_bready, u_rd_ok;

  // A U read must not overtake a U write that has been granted but not yet completed.
  assign u_rd_ok = !u_wbusy && !(w_state == W_ADDR && wgnt == GNT_U);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      rgnt    <= GNT_I;
      wgnt    <= GNT_I;
      u_wbusy <= 1'b0;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      rgnt    <= rgnt_next;
      wgnt    <= wgnt_next;
      if (m_awvalid && m_awready && wgnt == GNT_U)
        u_wbusy <= 1'b1;
      else if (m_bvalid && m_bready && wgnt == GNT_U)
        u_wbusy <= 1'b0;
    end
  end

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    r_next    = r_state;
    rgnt_next = rgnt;
    unique case (r_state)
      R_IDLE: begin
        if (u_arvalid && u_rd_ok) begin
          rgnt_next = GNT_U; r_next = R_ADDR;
        end else if (d_arvalid) begin
          rgnt_next = GNT_D; r_next = R_ADDR;
        end else if (i_arvalid) begin
          rgnt_next = GNT_I; r_next = R_ADDR;
        end
      end
      R_ADDR:  if (m_arvalid && m_arready) r_next = R_DATA;
      R_DATA:  if (m_rvalid && m_rready && m_rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next    = w_state;
    wgnt_next = wgnt;
    unique case (w_state)
      W_IDLE: begin
        if (u_awvalid) begin
          wgnt_next = GNT_U; w_next = W_ADDR;
        end else if (d_awvalid) begin
          wgnt_next = GNT_D; w_next = W_ADDR;
        end
      end
      W_ADDR:  if (m_awvalid && m_awready) w_next = W_DATA;
      W_DATA:  if (m_wvalid && m_wready && m_wlast) w_next = W_RESP;
      W_RESP:  if (m_bvalid && m_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Read-channel mux from the held grant.
  always_comb begin
    m_arid = ID_I; m_araddr = i_araddr; m_arlen = i_arlen; m_arsize = i_arsize;
    sel_arvalid = i_arvalid; sel_rready = i_rready;
    case (rgnt)
      GNT_D: begin
        m_arid = ID_D; m_araddr = d_araddr; m_arlen = d_arlen; m_arsize = d_arsize;
        sel_arvalid = d_arvalid; sel_rready = d_rready;
      end
      GNT_U: begin
        m_arid = ID_U; m_araddr = u_araddr; m_arlen = u_arlen; m_arsize = u_arsize;
        sel_arvalid = u_arvalid; sel_rready = u_rready;
      end
      default: ;
    endcase
  end

  assign m_arvalid = (r_state == R_ADDR) && sel_arvalid;
  assign m_rready  = (r_state == R_DATA) && sel_rready;
  assign i_arready = (r_state == R_ADDR) && rgnt == GNT_I && m_arready;
  assign d_arready = (r_state == R_ADDR) && rgnt == GNT_D && m_arready;
  assign u_arready = (r_state == R_ADDR) && rgnt == GNT_U && m_arready;
  assign i_rvalid  = (r_state == R_DATA) && rgnt == GNT_I && m_rvalid;
  assign d_rvalid  = (r_state == R_DATA) && rgnt == GNT_D && m_rvalid;
  assign u_rvalid  = (r_state == R_DATA) && rgnt == GNT_U && m_rvalid;
  assign i_rdata = m_rdata; assign d_rdata = m_rdata; assign u_rdata = m_rdata;
  assign i_rlast = m_rlast; assign d_rlast = m_rlast; assign u_rlast = m_rlast;

  // Write-channel mux; only D or U can hold the write grant.
  always_comb begin
    m_awid = ID_D; m_awaddr = d_awaddr; m_awlen = d_awlen; m_awsize = d_awsize;
    m_wdata = d_wdata; m_wstrb = d_wstrb; m_wlast = d_wlast;
    sel_wvalid = d_wvalid; sel_bready = d_bready;
    if (wgnt == GNT_U) begin
      m_awid = ID_U; m_awaddr = u_awaddr; m_awlen = u_awlen; m_awsize = u_awsize;
      m_wdata = u_wdata; m_wstrb = u_wstrb; m_wlast = u_wlast;
      sel_wvalid = u_wvalid; sel_bready = u_bready;
    end
  end

  assign m_awvalid = (w_state == W_ADDR) && (wgnt == GNT_U ? u_awvalid : d_awvalid);
  assign m_wvalid  = (w_state == W_DATA) && sel_wvalid;
  assign m_bready  = (w_state == W_RESP) && sel_bready;
  assign d_awready = (w_state == W_ADDR) && wgnt == GNT_D && m_awready;
  assign u_awready = (w_state == W_ADDR) && wgnt == GNT_U && m_awready;
  assign d_wready  = (w_state == W_DATA) && wgnt == GNT_D && m_wready;
  assign u_wready  = (w_state == W_DATA) && wgnt == GNT_U && m_wready;
  assign d_bvalid  = (w_state == W_RESP) && wgnt == GNT_D && m_bvalid;
  assign u_bvalid  = (w_state == W_RESP) && wgnt == GNT_U && m_bvalid;

endmodule
